// File: rtl/adder_sched_pkg.sv
// Shared types for the round-robin adder scheduler: data word, response
// register layout and output register state.
package adder_sched_pkg;

    localparam int DATA_W   = 64;
    localparam int MAX_ID_W = 3;   // enough for up to 8 requesters

    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        word_t               sum;
        logic                carry;
    } rsp_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/carry_lookahead_adder_64b.sv
// 64-bit adder: 4-bit lookahead groups, group generate/propagate chained
// across 16 groups.
module carry_lookahead_adder_64b (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        cin_i,
    output logic [63:0] sum_o,
    output logic        cout_o
);

    logic [63:0] g;
    logic [63:0] p;
    logic [64:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        c    = '0;
        c[0] = cin_i;
        for (int gi = 0; gi < 16; gi++) begin
            c[4*gi+1] = g[4*gi] | (p[4*gi] & c[4*gi]);
            c[4*gi+2] = g[4*gi+1] | (p[4*gi+1] & g[4*gi])
                      | (p[4*gi+1] & p[4*gi] & c[4*gi]);
            c[4*gi+3] = g[4*gi+2] | (p[4*gi+2] & g[4*gi+1])
                      | (p[4*gi+2] & p[4*gi+1] & g[4*gi])
                      | (p[4*gi+2] & p[4*gi+1] & p[4*gi] & c[4*gi]);
            // group generate | group propagate & group carry-in
            c[4*gi+4] = g[4*gi+3] | (p[4*gi+3] & g[4*gi+2])
                      | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                      | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi])
                      | (&p[4*gi +: 4] & c[4*gi]);
        end
    end

    assign sum_o  = p ^ c[63:0];
    assign cout_o = c[64];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the pointer with
// wrap; pointer moves past the winner only when accept_i strobes.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o
);

    logic [ID_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0] gnt;
    logic               found;
    int                 k;

    always_comb begin
        gnt       = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        k         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_q) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!found && req_i[k]) begin
                found     = 1'b1;
                gnt[k]    = 1'b1;
                gnt_idx_o = ID_W'(k);
            end
        end
    end

    assign gnt_o = en_i ? gnt : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= (gnt_idx_o == ID_W'(NUM_REQ-1)) ? '0 : ID_W'(gnt_idx_o + 1'b1);
        end
    end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one 64-bit adder among NUM_REQ requesters with round-robin grant and
// a single-entry response register. Define ADDER_RR_SCHEDULER_SUB_EN to add
// per-requester subtract (req_sub_i).
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_op1_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_op2_i,
    input  logic [NUM_REQ-1:0]        req_carry_i,
`ifdef ADDER_RR_SCHEDULER_SUB_EN
    input  logic [NUM_REQ-1:0]        req_sub_i,
`endif
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_sum_o,
    output logic                      rsp_carry_o
);

    out_state_e      state_q;
    rsp_t            rsp_q;
    logic            can_accept;
    logic            xfer;
    logic [ID_W-1:0] gnt_idx;
    word_t           op1;
    word_t           op2;
    logic            cin;
    word_t           sum;
    logic            cout;

    // Draining and refilling in the same cycle keeps one result per cycle.
    assign can_accept = (state_q == ST_EMPTY) | rsp_ready_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_valid_i),
        .en_i      (can_accept & rst_ni),
        .accept_i  (xfer),
        .gnt_o     (req_ready_o),
        .gnt_idx_o (gnt_idx)
    );

    assign xfer = |(req_valid_i & req_ready_o);

    always_comb begin
        op1 = req_op1_i[gnt_idx*DATA_W +: DATA_W];
        op2 = req_op2_i[gnt_idx*DATA_W +: DATA_W];
        cin = req_carry_i[gnt_idx];
`ifdef ADDER_RR_SCHEDULER_SUB_EN
        if (req_sub_i[gnt_idx]) begin
            op2 = ~op2;
            cin = 1'b1;
        end
`endif
    end

    carry_lookahead_adder_64b u_add (
        .a_i    (op1),
        .b_i    (op2),
        .cin_i  (cin),
        .sum_o  (sum),
        .cout_o (cout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            rsp_q   <= '0;
        end else if (xfer) begin
            state_q <= ST_FULL;
            rsp_q   <= '{id: MAX_ID_W'(gnt_idx), sum: sum, carry: cout};
        end else if (rsp_ready_i) begin
            state_q <= ST_EMPTY;
        end
    end

    assign rsp_valid_o = (state_q == ST_FULL);
    assign rsp_id_o    = ID_W'(rsp_q.id);
    assign rsp_sum_o   = rsp_q.sum;
    assign rsp_carry_o = rsp_q.carry;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler: vector table plus hand sequences for
// round-robin order, backpressure, fairness and mid-operation reset.
module tb_adder_rr_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_ni;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*64-1:0] req_op1;
    logic [N*64-1:0] req_op2;
    logic [N-1:0]   req_carry;
`ifdef ADDER_RR_SCHEDULER_SUB_EN
    logic [N-1:0]   req_sub;
`endif
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [63:0]    rsp_sum;
    logic           rsp_carry;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    adder_rr_scheduler #(.NUM_REQ(N)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op1_i   (req_op1),
        .req_op2_i   (req_op2),
        .req_carry_i (req_carry),
`ifdef ADDER_RR_SCHEDULER_SUB_EN
        .req_sub_i   (req_sub),
`endif
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_sum_o   (rsp_sum),
        .rsp_carry_o (rsp_carry)
    );

    typedef struct {
        int          req;
        logic [63:0] op1;
        logic [63:0] op2;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_req(input int k, input logic [63:0] a, input logic [63:0] b, input logic c);
        req_valid[k]          = 1'b1;
        req_op1[k*64 +: 64]   = a;
        req_op2[k*64 +: 64]   = b;
        req_carry[k]          = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string name, input logic [1:0] id, input logic [63:0] s, input logic c);
        chk({name, ".valid"}, 64'(rsp_valid), 64'd1);
        chk({name, ".id"},    64'(rsp_id),    64'(id));
        chk({name, ".sum"},   rsp_sum,        s);
        chk({name, ".carry"}, 64'(rsp_carry), 64'(c));
    endtask

    initial begin
        logic [63:0] held_sum;
        logic [N-1:0] one;

        vecs[0] = '{0, 64'd5, 64'd7, 1'b0, 64'd12, 1'b0};
        vecs[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1};
        vecs[2] = '{2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1};
        vecs[3] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1};
        vecs[4] = '{1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
                    64'h2222_2222_2222_2212, 1'b0};
        vecs[5] = '{2, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'd0, 1'b1};
        vecs[6] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[7] = '{3, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0};

        // reset with random inputs
        rst_ni    = 1'b0;
        req_valid = 4'($urandom) | 4'b0001;
        req_op1   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_op2   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        req_carry = 4'($urandom);
        rsp_ready = 1'b1;
`ifdef ADDER_RR_SCHEDULER_SUB_EN
        req_sub   = '0;
`endif
        tick();
        tick();
        chk("rst.valid", 64'(rsp_valid), 64'd0);
        chk("rst.ready", 64'(req_ready), 64'd0);
        chk("rst.sum",   rsp_sum,        64'd0);
        chk("rst.id",    64'(rsp_id),    64'd0);

        @(negedge clk);
        rst_ni    = 1'b1;
        req_valid = '0;

        // table: single requester each cycle, pass-through drain
        for (int v = 0; v < 8; v++) begin
            req_valid = '0;
            set_req(vecs[v].req, vecs[v].op1, vecs[v].op2, vecs[v].cin);
            #1;
            one = '0;
            one[vecs[v].req] = 1'b1;
            chk($sformatf("vec%0d.ready", v), 64'(req_ready), 64'(one));
            tick();
            chk_rsp($sformatf("vec%0d", v), 2'(vecs[v].req), vecs[v].sum, vecs[v].cout);
        end

        // all requesters valid: last grant was 3, so order 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < N; k++) set_req(k, 64'(1000*k + i), 64'(7*i), 1'b0);
            #1;
            one = '0;
            one[i % N] = 1'b1;
            chk($sformatf("rr%0d.ready", i), 64'(req_ready), 64'(one));
            tick();
            chk_rsp($sformatf("rr%0d", i), 2'(i % N), 64'(1000*(i % N) + 8*i), 1'b0);
        end

        // backpressure: FULL with id 0, requesters 1 and 2 waiting
        held_sum  = rsp_sum;
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d.ready", i), 64'(req_ready), 64'd0);
            tick();
            chk_rsp($sformatf("bp%0d", i), 2'd0, held_sum, 1'b0);
        end
        set_req(1, 64'd40, 64'd2, 1'b0);
        rsp_ready = 1'b1;
        #1;
        chk("bp_release.ready", 64'(req_ready), 64'b0010);
        tick();
        chk_rsp("bp_release", 2'd1, 64'd42, 1'b0);

        // fairness: grant 2, then 3 wins over 0
        req_valid = '0;
        set_req(2, 64'd100, 64'd1, 1'b1);
        #1;
        chk("fair2.ready", 64'(req_ready), 64'b0100);
        tick();
        chk_rsp("fair2", 2'd2, 64'd102, 1'b0);
        req_valid = '0;
        set_req(0, 64'd9, 64'd9, 1'b0);
        set_req(3, 64'd30, 64'd3, 1'b0);
        #1;
        chk("fair3.ready", 64'(req_ready), 64'b1000);
        tick();
        chk_rsp("fair3", 2'd3, 64'd33, 1'b0);
        req_valid[3] = 1'b0;
        #1;
        chk("fair0.ready", 64'(req_ready), 64'b0001);
        tick();
        chk_rsp("fair0", 2'd0, 64'd18, 1'b0);

        // drain with no new request: EMPTY, data held
        req_valid = '0;
        tick();
        chk("drain.valid", 64'(rsp_valid), 64'd0);
        chk("drain.sum",   rsp_sum,        64'd18);

`ifdef ADDER_RR_SCHEDULER_SUB_EN
        req_sub = 4'b0001;
        set_req(0, 64'd10, 64'd3, 1'b0);
        tick();
        chk_rsp("sub_pos", 2'd0, 64'd7, 1'b1);
        set_req(0, 64'd3, 64'd10, 1'b1);
        tick();
        chk_rsp("sub_neg", 2'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
        req_valid = '0;
        req_sub   = '0;
        tick();
`endif

        // mid-operation reset: FULL from requester 2 (pointer would be 3)
        set_req(2, 64'd5, 64'd5, 1'b0);
        tick();
        chk("pre_rst.valid", 64'(rsp_valid), 64'd1);
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_ni    = 1'b0;
        #1;
        chk("mid_rst.valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst.sum",   rsp_sum,        64'd0);
        @(negedge clk);
        rst_ni    = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 64'd1, 64'd1, 1'b0);
        set_req(3, 64'd2, 64'd2, 1'b0);
        #1;
        chk("post_rst.ready", 64'(req_ready), 64'b0001);
        tick();
        chk_rsp("post_rst", 2'd0, 64'd2, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
